// File: rtl/bubble_page_buffer.sv
// Bubble page buffer: captures one loader page into a 1-bit RAM, then serialises it on bubble strobes.
// Optional ones-count on the serial stream is built when PAGEBUF_CHKSUM_EN is defined.
module bubble_page_buffer #(
    parameter int ADDR_W    = 15,
    parameter int PAGE_BITS = 4096
) (
    input  logic              MCLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] OUTBUFWADDR,
    input  logic              OUTBUFWDATA,
    input  logic              OUTBUFWCLK,
    input  logic              ARM,
    input  logic              BITSTB,
    output logic              DOUT,
    output logic              DOUTVALID,
    output logic              PAGEREADY,
    output logic              BUSY,
    output logic              UNDERRUN,
    output logic [15:0]       CHKSUM
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_READY = 2'd2;
    localparam logic [1:0] S_SHIFT = 2'd3;

    localparam logic [ADDR_W:0] PAGE_N = (ADDR_W+1)'(PAGE_BITS);
    localparam logic [ADDR_W:0] LAST   = (ADDR_W+1)'(PAGE_BITS - 1);

    logic [1:0]      state;
    logic            wclk_d;
    logic [ADDR_W:0] wcount;
    logic [ADDR_W:0] rcount;
    logic [ADDR_W:0] wcount_inc;
    logic            write;
    logic            rd_req;
    logic            under_req;
    logic            ram_q;
    logic            rd_vld;
    logic            rd_zero;

    logic mem [0:(1<<ADDR_W)-1];

    assign write      = OUTBUFWCLK & ~wclk_d;
    assign wcount_inc = wcount + 1'b1;
    // ARM wins over a coincident strobe: the strobe belongs to the page being abandoned.
    assign rd_req     = BITSTB & ~ARM & ((state == S_READY) | (state == S_SHIFT));
    assign under_req  = BITSTB & ~ARM & (state == S_FILL);
    assign BUSY       = (state != S_IDLE);

    // Read-before-write: a same-address read in the write cycle returns the old bit.
    always_ff @(posedge MCLK) begin
        if (write)  mem[OUTBUFWADDR] <= OUTBUFWDATA;
        if (rd_req) ram_q <= mem[rcount[ADDR_W-1:0]];
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            wclk_d    <= 1'b0;
            rd_vld    <= 1'b0;
            rd_zero   <= 1'b0;
            DOUT      <= 1'b0;
            DOUTVALID <= 1'b0;
        end else begin
            wclk_d    <= OUTBUFWCLK;
            rd_vld    <= rd_req | under_req;
            rd_zero   <= under_req;
            DOUTVALID <= rd_vld;
            if (rd_vld) DOUT <= ram_q & ~rd_zero;
        end
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            wcount    <= '0;
            rcount    <= '0;
            PAGEREADY <= 1'b0;
            UNDERRUN  <= 1'b0;
        end else if (ARM) begin
            wcount   <= {{ADDR_W{1'b0}}, write};
            rcount   <= '0;
            UNDERRUN <= 1'b0;
            if (write && PAGE_N == 1) begin
                state     <= S_READY;
                PAGEREADY <= 1'b1;
            end else begin
                state     <= S_FILL;
                PAGEREADY <= 1'b0;
            end
        end else begin
            case (state)
                S_FILL: begin
                    if (under_req) UNDERRUN <= 1'b1;
                    if (write) begin
                        if (wcount_inc >= PAGE_N) begin
                            wcount    <= PAGE_N;
                            state     <= S_READY;
                            PAGEREADY <= 1'b1;
                        end else begin
                            wcount <= wcount_inc;
                        end
                    end
                end
                S_READY, S_SHIFT: begin
                    if (rd_req) begin
                        rcount <= rcount + 1'b1;
                        if (rcount == LAST) begin
                            state     <= S_IDLE;
                            PAGEREADY <= 1'b0;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PAGEBUF_CHKSUM_EN
    logic [15:0] chk;

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET)                  chk <= '0;
        else if (ARM)               chk <= '0;
        else if (DOUTVALID && DOUT) chk <= chk + 16'd1;
    end

    assign CHKSUM = chk;
`else
    assign CHKSUM = 16'd0;
`endif

endmodule

// File: tb/tb_bubble_page_buffer.sv
// Bench for bubble_page_buffer: per-cycle comparison against a queue-based page model plus directed literal checks.
module tb_bubble_page_buffer;
    localparam int AW = 4;
    localparam int PB = 8;
`ifdef PAGEBUF_CHKSUM_EN
    localparam int CHK_ON = 1;
`else
    localparam int CHK_ON = 0;
`endif

    logic          MCLK = 1'b0;
    logic          RESET = 1'b1;
    logic [AW-1:0] OUTBUFWADDR = '0;
    logic          OUTBUFWDATA = 1'b0;
    logic          OUTBUFWCLK = 1'b0;
    logic          ARM = 1'b0;
    logic          BITSTB = 1'b0;
    logic          DOUT, DOUTVALID, PAGEREADY, BUSY, UNDERRUN;
    logic [15:0]   CHKSUM;

    bubble_page_buffer #(.ADDR_W(AW), .PAGE_BITS(PB)) dut (
        .MCLK(MCLK), .RESET(RESET), .OUTBUFWADDR(OUTBUFWADDR), .OUTBUFWDATA(OUTBUFWDATA),
        .OUTBUFWCLK(OUTBUFWCLK), .ARM(ARM), .BITSTB(BITSTB), .DOUT(DOUT), .DOUTVALID(DOUTVALID),
        .PAGEREADY(PAGEREADY), .BUSY(BUSY), .UNDERRUN(UNDERRUN), .CHKSUM(CHKSUM)
    );

    always #5 MCLK = ~MCLK;

    int n_chk = 0;
    int n_pass = 0;

    // Page model: mode 0 = no page activity, 1 = filling, 2 = page held for shifting.
    typedef struct { int due; logic b; } ev_t;
    ev_t         q[$];
    int          cyc = 0;
    int          mode = 0;
    int          wcnt = 0;
    int          rcnt = 0;
    logic        m_mem [0:(1<<AW)-1];
    logic        m_wclk_d = 1'b0;
    logic        m_wr;
    logic        m_dv = 1'b0, m_dout = 1'b0, m_pr = 1'b0, m_ur = 1'b0;
    logic [15:0] m_chk = '0;

    always @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            q.delete();
            mode = 0; wcnt = 0; rcnt = 0; m_wclk_d = 1'b0;
            m_dv = 1'b0; m_dout = 1'b0; m_pr = 1'b0; m_ur = 1'b0; m_chk = '0;
        end else begin
            if (m_dv && m_dout) m_chk = m_chk + 16'd1;
            m_dv = 1'b0;
            if (q.size() > 0 && q[0].due == cyc) begin
                m_dv = 1'b1;
                m_dout = q[0].b;
                void'(q.pop_front());
            end
            m_wr = OUTBUFWCLK && !m_wclk_d;
            if (ARM) begin
                mode = 1; wcnt = m_wr ? 1 : 0; rcnt = 0;
                m_ur = 1'b0; m_pr = 1'b0; m_chk = '0;
                if (wcnt == PB) begin mode = 2; m_pr = 1'b1; end
            end else if (mode == 1) begin
                if (BITSTB) begin
                    m_ur = 1'b1;
                    q.push_back('{due: cyc + 1, b: 1'b0});
                end
                if (m_wr) begin
                    wcnt = (wcnt + 1 > PB) ? PB : wcnt + 1;
                    if (wcnt == PB) begin mode = 2; m_pr = 1'b1; end
                end
            end else if (mode == 2 && BITSTB) begin
                q.push_back('{due: cyc + 1, b: m_mem[rcnt]});
                rcnt++;
                if (rcnt == PB) begin mode = 0; m_pr = 1'b0; end
            end
            if (m_wr) m_mem[OUTBUFWADDR] = OUTBUFWDATA;
            m_wclk_d = OUTBUFWCLK;
            cyc++;
        end
    end

    logic [20:0] cmp_got, cmp_exp;
    always @(negedge MCLK) begin
        cmp_got = {DOUTVALID, DOUT, PAGEREADY, BUSY, UNDERRUN, CHKSUM};
        cmp_exp = {m_dv, m_dout, m_pr, (mode != 0), m_ur, (CHK_ON != 0) ? m_chk : 16'd0};
        n_chk++;
        if (cmp_got === cmp_exp) n_pass++;
        else $display("FAIL model t=%0t got{dv,dout,pr,busy,ur,chk}=%h expected=%h", $time, cmp_got, cmp_exp);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    endtask

    task automatic step();
        @(negedge MCLK);
    endtask

    task automatic wr(input int a, input logic d);
        OUTBUFWADDR = a[AW-1:0];
        OUTBUFWDATA = d;
        OUTBUFWCLK  = 1'b1;
        step();
        OUTBUFWCLK  = 1'b0;
        step();
    endtask

    task automatic arm_pulse();
        ARM = 1'b1;
        step();
        ARM = 1'b0;
    endtask

    // Address i receives pat[7-i], so the shifted stream reads pat MSB first.
    task automatic fill_part(input logic [7:0] pat, input int from, input int to);
        for (int i = from; i <= to; i++) wr(i, pat[7-i]);
    endtask

    task automatic shift(input int n, output logic [15:0] bits, output int lat, output int fall);
        bits = '0; lat = -1; fall = -1;
        for (int i = 0; i < n + 3; i++) begin
            BITSTB = (i < n);
            step();
            if (DOUTVALID) begin
                bits = {bits[14:0], DOUT};
                if (lat < 0) lat = i + 1;
            end
            if (fall < 0 && !PAGEREADY) fall = i;
        end
        BITSTB = 1'b0;
    endtask

    logic [15:0] bits;
    int          lat, fall;
    logic        dv_seen;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        chk("reset_outputs", {11'd0, DOUTVALID, DOUT, PAGEREADY, BUSY, UNDERRUN, CHKSUM}, 32'd0);
        RESET = 1'b0;
        step();

        // Strobes in idle are ignored.
        dv_seen = 1'b0;
        BITSTB = 1'b1; step(); BITSTB = 1'b0;
        repeat (3) begin step(); dv_seen |= DOUTVALID; end
        chk("idle_strobe_dv", dv_seen, 0);
        chk("idle_busy", BUSY, 0);

        // Basic fill and shift.
        arm_pulse();
        chk("arm_busy", BUSY, 1);
        fill_part(8'hB2, 0, 6);
        chk("pr_before_8th", PAGEREADY, 0);
        fill_part(8'hB2, 7, 7);
        chk("pr_after_8th", PAGEREADY, 1);
        shift(8, bits, lat, fall);
        chk("stream_b2", bits[7:0], 8'hB2);
        chk("first_dv_latency", lat, 2);
        chk("pr_fall_step", fall, 7);
        chk("busy_after_shift", BUSY, 0);
        chk("chksum_b2", CHKSUM, CHK_ON ? 4 : 0);

        // Underrun: strobe during fill gives a zero bit and does not consume a read address.
        arm_pulse();
        fill_part(8'h69, 0, 2);
        BITSTB = 1'b1; step(); BITSTB = 1'b0;
        chk("underrun_set", UNDERRUN, 1);
        step();
        chk("underrun_dv_dout", {DOUTVALID, DOUT}, 2'b10);
        fill_part(8'h69, 3, 7);
        chk("underrun_pr", PAGEREADY, 1);
        chk("underrun_sticky", UNDERRUN, 1);
        shift(8, bits, lat, fall);
        chk("stream_69_from_addr0", bits[7:0], 8'h69);

        // A write strobe held high for 5 cycles counts once.
        arm_pulse();
        OUTBUFWADDR = '0; OUTBUFWDATA = 1'b1; OUTBUFWCLK = 1'b1;
        repeat (5) step();
        OUTBUFWCLK = 1'b0;
        step();
        fill_part(8'hC3, 1, 6);
        chk("wide_strobe_pr_7", PAGEREADY, 0);
        fill_part(8'hC3, 7, 7);
        chk("wide_strobe_pr_8", PAGEREADY, 1);

        // ARM mid-shift aborts the page and restarts from address 0.
        shift(3, bits, lat, fall);
        chk("partial_stream", bits[2:0], 3'b110);
        chk("chksum_partial", CHKSUM, CHK_ON ? 2 : 0);
        arm_pulse();
        chk("rearm_pr", PAGEREADY, 0);
        chk("rearm_ur", UNDERRUN, 0);
        chk("rearm_chksum", CHKSUM, 0);
        chk("rearm_busy", BUSY, 1);
        fill_part(8'h5A, 0, 7);
        shift(8, bits, lat, fall);
        chk("stream_5a", bits[7:0], 8'h5A);

        // Reset mid-fill acts asynchronously.
        arm_pulse();
        fill_part(8'h3C, 0, 3);
        chk("midfill_busy", BUSY, 1);
        #2 RESET = 1'b1;
        #1 chk("async_reset_busy", BUSY, 0);
        chk("async_reset_pr", PAGEREADY, 0);
        step();
        RESET = 1'b0;
        step();
        arm_pulse();
        fill_part(8'h3C, 0, 6);
        chk("post_reset_pr_7", PAGEREADY, 0);
        fill_part(8'h3C, 7, 7);
        chk("post_reset_pr_8", PAGEREADY, 1);
        shift(8, bits, lat, fall);
        chk("stream_3c", bits[7:0], 8'h3C);

        step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
